// File: rtl/seq_muldiv.sv
// Sequential multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, on operand magnitudes.
// The result sign is applied afterwards in a single fix-up cycle.
module seq_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPrep = 3'd1;
  localparam logic [2:0] StRun  = 3'd2;
  localparam logic [2:0] StFix  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;      // sign of product / quotient
  logic             neg_rem_q;  // sign of remainder (follows dividend)
  logic [WIDTH-1:0] bmag_q;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] phi_q;      // partial product upper half / running remainder
  logic [WIDTH-1:0] plo_q;      // multiplier bits / dividend bits shifting into quotient

  logic             is_div, is_signed, a_neg, b_neg, b_zero, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] dsub;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] res_hi, res_lo;

  // Operand decode, per-iteration step and final sign correction.
  always_comb begin
    is_div    = op_q[1];
    is_signed = ~op_q[0];
    a_neg     = is_signed & a_q[WIDTH-1];
    b_neg     = is_signed & b_q[WIDTH-1];
    a_mag     = a_neg ? -a_q : a_q;
    b_mag     = b_neg ? -b_q : b_q;
    b_zero    = (b_q == '0);
    accept    = (state_q == StIdle) && start;

    // Multiply: add multiplicand when the current multiplier bit is set, then shift right.
    msum      = {1'b0, phi_q} + (plo_q[0] ? {1'b0, bmag_q} : '0);
    // Divide: shift in the next dividend bit and subtract when it fits.
    shifted   = {phi_q, plo_q[WIDTH-1]};
    ge        = (shifted >= {1'b0, bmag_q});
    dsub      = shifted[WIDTH-1:0] - bmag_q;

    if (is_div) begin
      step_hi = ge ? dsub : shifted[WIDTH-1:0];
      step_lo = {plo_q[WIDTH-2:0], ge};
    end else begin
      {step_hi, step_lo} = {msum, plo_q[WIDTH-1:1]};
    end

    prod_fix = neg_q ? -{phi_q, plo_q} : {phi_q, plo_q};
    if (is_div) begin
      res_hi = neg_rem_q ? -phi_q : phi_q;
      res_lo = neg_q ? -plo_q : plo_q;
    end else begin
      {res_hi, res_lo} = prod_fix;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StPrep;
      StPrep:  state_d = (is_div && b_zero) ? StDone : StRun;
      StRun:   if (cnt_q == LastIter) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Operand capture; only an accepted start updates these.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
  end

  // Iterative datapath: magnitude setup in PREP, one bit per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      bmag_q    <= '0;
      phi_q     <= '0;
      plo_q     <= '0;
    end else if (state_q == StPrep) begin
      cnt_q     <= '0;
      neg_q     <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      bmag_q    <= b_mag;
      phi_q     <= '0;
      plo_q     <= a_mag;
    end else if (state_q == StRun) begin
      cnt_q <= cnt_q + 1'b1;
      phi_q <= step_hi;
      plo_q <= step_lo;
    end
  end

  // Result registers change only on entry to DONE; div_zero clears on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      div_zero <= 1'b0;
    end else if (state_q == StPrep && is_div && b_zero) begin
      hi       <= a_q;
      lo       <= '1;
      div_zero <= 1'b1;
    end else if (state_q == StFix) begin
      hi <= res_hi;
      lo <= res_lo;
    end
  end

  assign busy = (state_q == StPrep) || (state_q == StRun) || (state_q == StFix);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_seq_muldiv.sv
// Self-checking bench for seq_muldiv (WIDTH = 32).
// Latencies are counted in rising edges with the edge that samples start as edge 1.
module tb_seq_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  seq_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, eh, el;
    logic         ez;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic.
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic ez);
    longint sx, sy, r;
    longint unsigned ux, uy, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    ez = 1'b0;
    eh = '0;
    el = '0;
    if (o == 2'b00) begin
      r = sx * sy; eh = r[63:32]; el = r[31:0];
    end else if (o == 2'b01) begin
      ur = ux * uy; eh = ur[63:32]; el = ur[31:0];
    end else if (y == 0) begin
      eh = x; el = '1; ez = 1'b1;
    end else if (o == 2'b10) begin
      r = sx / sy; el = r[31:0];
      r = sx % sy; eh = r[31:0];
    end else begin
      ur = ux / uy; el = ur[31:0];
      ur = ux % uy; eh = ur[31:0];
    end
  endtask

  // Wait (bounded) for done; returns edge index with the start edge as edge 1, 0 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  // Issue one operation, scramble inputs after the start edge, collect the result.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rz,
                        output int lat);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    wait_done(lat);
    rh = hi; rl = lo; rz = div_zero;
    @(posedge clk); #1;
    chk("done_single_pulse", done, 1'b0);
  endtask

  task automatic check_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y);
    logic [W-1:0] rh, rl, eh, el;
    logic rz, ez;
    int lat;
    run_op(o, x, y, rh, rl, rz, lat);
    model(o, x, y, eh, el, ez);
    chk({name, "_latency"}, lat, ez ? 2 : W + 3);
    chk({name, "_hi"}, rh, eh);
    chk({name, "_lo"}, rl, el);
    chk({name, "_div_zero"}, rz, ez);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    logic [W-1:0] x, y, eh, el, rh, rl;
    logic ez, rz;
    int lat, cnt;

    vt.push_back('{op: 2'b00, a: 32'hFFFFFFFD, b: 32'd5,        eh: 32'hFFFFFFFF, el: 32'hFFFFFFF1, ez: 1'b0});
    vt.push_back('{op: 2'b01, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, eh: 32'hFFFFFFFE, el: 32'h00000001, ez: 1'b0});
    vt.push_back('{op: 2'b00, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, eh: 32'h0,        el: 32'h1,        ez: 1'b0});
    vt.push_back('{op: 2'b10, a: 32'hFFFFFFF9, b: 32'd2,        eh: 32'hFFFFFFFF, el: 32'hFFFFFFFD, ez: 1'b0});
    vt.push_back('{op: 2'b11, a: 32'd100,      b: 32'd7,        eh: 32'd2,        el: 32'd14,       ez: 1'b0});
    vt.push_back('{op: 2'b10, a: 32'h80000000, b: 32'hFFFFFFFF, eh: 32'h0,        el: 32'h80000000, ez: 1'b0});
    vt.push_back('{op: 2'b11, a: 32'd7,        b: 32'd100,      eh: 32'd7,        el: 32'd0,        ez: 1'b0});
    vt.push_back('{op: 2'b10, a: 32'd7,        b: 32'hFFFFFFFE, eh: 32'd1,        el: 32'hFFFFFFFD, ez: 1'b0});
    vt.push_back('{op: 2'b10, a: 32'h10,       b: 32'd0,        eh: 32'h10,       el: 32'hFFFFFFFF, ez: 1'b1});

    // Reset state.
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_flags", {busy, done, div_zero}, 3'b000);

    // First start after release is accepted on the first edge.
    @(negedge clk);
    reset = 1'b0; op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_start_busy", busy, 1'b1);
    wait_done(lat);
    chk("first_start_latency", lat, W + 3);
    chk("first_start_lo", lo, 32'd12);
    chk("busy_in_done", busy, 1'b0);
    @(posedge clk); #1;

    // Directed vectors.
    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, rh, rl, rz, lat);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].ez ? 2 : W + 3);
      chk($sformatf("vec%0d_hi", i), rh, vt[i].eh);
      chk($sformatf("vec%0d_lo", i), rl, vt[i].el);
      chk($sformatf("vec%0d_div_zero", i), rz, vt[i].ez);
    end

    // div_zero held in IDLE, then cleared by the accepting edge of the next start.
    chk("dz_held", div_zero, 1'b1);
    @(negedge clk);
    op = 2'b01; a = 32'h12345678; b = 32'h9ABCDEF1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dz_cleared", div_zero, 1'b0);
    wait_done(lat);
    @(posedge clk); #1;

    // Reset in the middle of a multiply: outputs clear at once, no done afterwards.
    @(negedge clk);
    op = 2'b00; a = 32'h0BADF00D; b = 32'h00C0FFEE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midreset_hi", hi, 0);
    chk("midreset_lo", lo, 0);
    chk("midreset_flags", {busy, done, div_zero}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    chk("midreset_no_activity", cnt, 0);

    // start held high through the operation with changing inputs: one result, from latched operands.
    x = 32'hFFFF1234; y = 32'h00054321;
    @(negedge clk);
    op = 2'b00; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n + 1;
        break;
      end
      a = $urandom; b = $urandom; op = 2'($urandom);
    end
    start = 1'b0;
    model(2'b00, x, y, eh, el, ez);
    chk("held_start_latency", lat, W + 3);
    chk("held_start_hi", hi, eh);
    chk("held_start_lo", lo, el);
    cnt = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk("held_start_extra_done", cnt, 0);
    chk("held_start_hold_lo", lo, el);

    // Randomised operations against the reference model.
    for (int i = 0; i < 200; i++) begin
      x = $urandom;
      case ($urandom_range(0, 9))
        0: y = '0;
        1: y = 32'($urandom_range(1, 15));
        2: y = '1;
        3: y = 32'h80000000;
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      check_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), x, y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
